// File: rtl/pwm_dac.sv
// PWM audio-style DAC with a one-entry sample buffer and a sticky underrun flag.
// Define PWM_DAC_SDM_EN to replace the PWM comparator with a first-order sigma-delta modulator.
module pwm_dac #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             pwm,
  output logic             period_start,
  output logic             underrun
);

  localparam logic [WIDTH-1:0] CNT_LAST = '1;

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] act;
  logic [WIDTH-1:0] pend;
  logic             full;
  logic             underrun_q;
  logic             pwm_bit_c;
  logic             terminal_c;
  logic             accept_c;

  // Handshake and period markers; all outputs are held low while in reset.
  assign din_ready    = !full && !rst;
  assign accept_c     = din_valid && din_ready;
  assign terminal_c   = (cnt == CNT_LAST);
  assign period_start = (cnt == '0) && !rst;
  assign underrun     = underrun_q && !rst;
  assign pwm          = pwm_bit_c && !rst;

  // Free-running period counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + WIDTH'(1);
    end
  end

  // Pending buffer and active duty; the active value only changes at the period boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend       <= '0;
      full       <= 1'b0;
      act        <= '0;
      underrun_q <= 1'b0;
    end else if (terminal_c) begin
      if (full) begin
        act  <= pend;
        full <= 1'b0;
      end else if (accept_c) begin
        act <= din;
      end else begin
        underrun_q <= 1'b1;
      end
    end else if (accept_c) begin
      pend <= din;
      full <= 1'b1;
    end
  end

`ifdef PWM_DAC_SDM_EN
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [WIDTH:0]   sum_c;

  // Accumulator runs across period boundaries; only reset clears it.
  assign sum_c = {1'b0, acc} + {1'b0, act};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      carry <= 1'b0;
    end else begin
      acc   <= sum_c[WIDTH-1:0];
      carry <= sum_c[WIDTH];
    end
  end

  assign pwm_bit_c = carry;
`else
  assign pwm_bit_c = (cnt < act);
`endif

endmodule

// File: tb/tb_pwm_dac.sv
// Self-checking bench for pwm_dac: reset table, directed period scenarios, and
// randomized traffic against a cycle-count based reference model.
module tb_pwm_dac;

  localparam int unsigned WIDTH = 8;
  localparam int PERIOD = 256;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] din = '0;
  logic             din_valid = 1'b0;
  logic             din_ready;
  logic             pwm;
  logic             period_start;
  logic             underrun;

  always #5 clk = ~clk;

  pwm_dac #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .din_valid    (din_valid),
    .din_ready    (din_ready),
    .pwm          (pwm),
    .period_start (period_start),
    .underrun     (underrun)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: time measured in cycles since reset release.
  int cyc = 0;
  int act_m = 0;
  int pend_q[$];
  bit und_m = 1'b0;
  int acc_m = 0;
  bit carry_m = 1'b0;

  logic s_ready, s_pstart, s_pwm, s_und;
  int   s_cnt;

  typedef struct {
    logic       r;
    logic       v;
    logic [7:0] d;
    logic       e_ready;
    logic       e_pstart;
    logic       e_pwm;
    logic       e_und;
  } vec_t;

  vec_t vecs[5];

  int   highs, first_low, bad;
  logic last_pwm, ready0, und0;
  int   last_one;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic [7:0] d);
    bit e_ready, e_pstart, e_pwm, e_und, take;
    int sum;
    @(negedge clk);
    rst = r;
    din_valid = v;
    din = d;
    #1;
    s_ready  = din_ready;
    s_pstart = period_start;
    s_pwm    = pwm;
    s_und    = underrun;
    s_cnt    = cyc % PERIOD;
    e_ready  = !r && (pend_q.size() == 0);
    e_pstart = !r && (s_cnt == 0);
`ifdef PWM_DAC_SDM_EN
    e_pwm    = !r && carry_m;
`else
    e_pwm    = !r && (s_cnt < act_m);
`endif
    e_und    = !r && und_m;
    check("model_din_ready", s_ready, e_ready);
    check("model_period_start", s_pstart, e_pstart);
    check("model_pwm", s_pwm, e_pwm);
    check("model_underrun", s_und, e_und);
    @(posedge clk);
    if (r) begin
      cyc = 0; act_m = 0; pend_q.delete(); und_m = 0; acc_m = 0; carry_m = 0;
    end else begin
      take = v && (pend_q.size() == 0);
      sum = acc_m + act_m;
      carry_m = (sum >= PERIOD);
      acc_m = sum % PERIOD;
      if (s_cnt == PERIOD - 1) begin
        if (pend_q.size() != 0) act_m = pend_q.pop_front();
        else if (take) act_m = int'(d);
        else und_m = 1'b1;
      end else if (take) begin
        pend_q.push_back(int'(d));
      end
      cyc++;
    end
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);
  endtask

  task automatic run_to_cnt(input int c);
    for (int i = 0; i < PERIOD + 1; i++) begin
      if (cyc % PERIOD == c) break;
      cycle(1'b0, 1'b0, 8'h00);
    end
  endtask

  // One full period from cnt 0; optionally offers a sample on its first cycle.
  task automatic measure_period(input logic v0, input logic [7:0] d0, output int h,
                                output int fl, output logic lp, output logic rdy0,
                                output logic u0);
    h = 0; fl = -1; lp = 1'b0; rdy0 = 1'b0; u0 = 1'b0;
    for (int i = 0; i < PERIOD; i++) begin
      if (i == 0) cycle(1'b0, v0, d0);
      else cycle(1'b0, 1'b0, 8'h00);
      if (i == 0) begin rdy0 = s_ready; u0 = s_und; end
      if (s_pwm === 1'b1) h++;
      else if (fl < 0) fl = i;
      lp = s_pwm;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'h40, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 5; i++) begin
      cycle(vecs[i].r, vecs[i].v, vecs[i].d);
      check("vec_din_ready", s_ready, vecs[i].e_ready);
      check("vec_period_start", s_pstart, vecs[i].e_pstart);
      check("vec_pwm", s_pwm, vecs[i].e_pwm);
      check("vec_underrun", s_und, vecs[i].e_und);
    end

`ifndef PWM_DAC_SDM_EN
    // 0x40 accepted in period 0 drives period 1.
    run_to_cnt(0);
    measure_period(1'b0, 8'h00, highs, first_low, last_pwm, ready0, und0);
    check("p40_highs", highs, 64);
    check("p40_first_low", first_low, 64);
    check("p40_und_before_end", s_und, 0);
    cycle(1'b0, 1'b0, 8'h00);
    check("p40_underrun_set", s_und, 1);
    check("p40_duty_retained", s_pwm, 1);

    // 0x00 then 0xFF.
    do_reset();
    cycle(1'b0, 1'b1, 8'h00);
    run_to_cnt(0);
    measure_period(1'b1, 8'hFF, highs, first_low, last_pwm, ready0, und0);
    check("zero_highs", highs, 0);
    measure_period(1'b0, 8'h00, highs, first_low, last_pwm, ready0, und0);
    check("full_highs", highs, 255);
    check("full_first_low", first_low, 255);
    check("full_last_low", last_pwm, 0);

    // Back-to-back offers at cnt 10.
    do_reset();
    run_to_cnt(10);
    cycle(1'b0, 1'b1, 8'h11);
    check("b2b_first_ready", s_ready, 1);
    bad = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (cyc % PERIOD == 0) break;
      cycle(1'b0, 1'b1, 8'h22);
      if (s_ready !== 1'b0) bad++;
    end
    check("b2b_ready_low_while_full", bad, 0);
    measure_period(1'b1, 8'h22, highs, first_low, last_pwm, ready0, und0);
    check("b2b_second_ready_at_cnt0", ready0, 1);
    check("b2b_first_highs", highs, 17);
    measure_period(1'b0, 8'h00, highs, first_low, last_pwm, ready0, und0);
    check("b2b_second_highs", highs, 34);

    // Sample accepted exactly on the terminal cycle with an empty buffer.
    do_reset();
    run_to_cnt(255);
    cycle(1'b0, 1'b1, 8'h80);
    check("term_ready", s_ready, 1);
    measure_period(1'b0, 8'h00, highs, first_low, last_pwm, ready0, und0);
    check("term_highs", highs, 128);
    check("term_no_underrun", und0, 0);

    // Underrun with retained duty, then mid-period reset.
    do_reset();
    cycle(1'b0, 1'b1, 8'h20);
    run_to_cnt(0);
    measure_period(1'b0, 8'h00, highs, first_low, last_pwm, ready0, und0);
    check("ur_p1_highs", highs, 32);
    check("ur_p1_und", und0, 0);
    measure_period(1'b0, 8'h00, highs, first_low, last_pwm, ready0, und0);
    check("ur_p2_highs", highs, 32);
    check("ur_p2_und", und0, 1);
    run_to_cnt(100);
    cycle(1'b1, 1'b0, 8'h00);
    check("rst_ready", s_ready, 0);
    check("rst_pstart", s_pstart, 0);
    check("rst_pwm", s_pwm, 0);
    check("rst_und", s_und, 0);
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    check("rel_pstart", s_pstart, 1);
    check("rel_ready", s_ready, 1);
    check("rel_und", s_und, 0);
`else
    // Sigma-delta: 0x40 gives a one every 4th cycle.
    do_reset();
    cycle(1'b0, 1'b1, 8'h40);
    run_to_cnt(0);
    measure_period(1'b1, 8'h40, highs, first_low, last_pwm, ready0, und0);
    highs = 0; bad = 0; last_one = -1;
    for (int i = 0; i < PERIOD; i++) begin
      cycle(1'b0, 1'b0, 8'h00);
      if (s_pwm === 1'b1) begin
        highs++;
        if (last_one >= 0 && i - last_one != 4) bad++;
        last_one = i;
      end
    end
    check("sdm_ones", highs, 64);
    check("sdm_spacing", bad, 0);
`endif

    // Randomized traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 599) == 0), ($urandom_range(0, 149) == 0), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_dac.md
PWM_DAC -- requirements
Module: pwm_dac

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the sample resolution in bits; the PWM period is 2^WIDTH clk cycles.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port din, input, WIDTH bits: unsigned duty sample.
REQ-005 SHALL have port din_valid, input, 1 bit: din is presented.
REQ-006 SHALL have port din_ready, output, 1 bit: the block can accept a sample.
REQ-007 SHALL have port pwm, output, 1 bit: 1-bit DAC stream that drives the downstream RC lowpass input (port 1 of the R-C stage).
REQ-008 SHALL have port period_start, output, 1 bit: pulse on the first cycle of each period.
REQ-009 SHALL have port underrun, output, 1 bit: sticky flag; a period ended with no new sample.

Function
REQ-010 SHALL keep a WIDTH-bit free-running counter cnt.
- cnt increments every cycle.
- cnt wraps from 2^WIDTH-1 to 0.
- The cycle with cnt==2^WIDTH-1 is the terminal cycle.
REQ-011 SHALL hold a one-entry pending buffer (pend, full) and an active duty register act.
REQ-012 SHALL drive din_ready = !full && !rst, combinationally.
REQ-013 SHALL accept a sample on any cycle where din_valid && din_ready; acceptance writes pend<=din and full<=1, except as REQ-015 states.
REQ-014 SHALL, on the terminal cycle with full==1, load act<=pend and clear full; din_ready is therefore high from the next cycle.
REQ-015 SHALL, on the terminal cycle with full==0 and an accepted sample, load act<=din directly, leave full at 0, and not set underrun.
REQ-016 SHALL, on the terminal cycle with full==0 and no accepted sample, retain act and set underrun<=1.
REQ-017 SHALL apply a new act value from the cycle where cnt==0, so a sample accepted in period k takes effect for all of period k+1.
REQ-018 SHALL, in PWM mode, drive pwm = (cnt < act) from registered cnt and act; the comparison is unsigned.
- act=0 gives pwm low for the whole period.
- act=2^WIDTH-1 gives pwm low only on the terminal cycle.
REQ-019 SHALL drive period_start = (cnt==0) && !rst.
REQ-020 SHALL keep underrun set until rst; no other event clears it.

Reset
REQ-021 SHALL, while rst is high, force the following values:
- cnt=0, act=0, pend=0, full=0, underrun=0;
- pwm=0, din_ready=0, period_start=0.
REQ-022 SHALL, on reset asserted mid-period, discard both the pending and the active sample.
REQ-023 SHALL start the counting after reset release at cnt=0, with period_start high on that first cycle.

Configuration
REQ-024 SHALL honour macro PWM_DAC_SDM_EN as the only compile-time option.
REQ-025 SHALL, with PWM_DAC_SDM_EN undefined, operate as the PWM described in REQ-018.
REQ-026 SHALL, with PWM_DAC_SDM_EN defined, replace REQ-018 with a first-order sigma-delta modulator:
- uses a WIDTH-bit accumulator acc;
- each cycle {carry,acc} <= acc + act;
- pwm is the registered carry.
The counter, buffer, handshake, period_start and underrun behave identically in both modes.
REQ-027 SHALL, in SDM mode, reset acc to 0, and SHALL NOT reset acc at period boundaries.

Verification
REQ-028 SHALL cover: reset, then din=0x40 accepted during period 0 -> in period 1 pwm high for cnt 0..63 and low for 192 cycles; underrun=0.
REQ-029 SHALL cover: din=0x00, then din=0xFF -> one period of pwm low for all 256 cycles, then one period with pwm high for 255 cycles and low only at cnt=255.
REQ-030 SHALL cover: two samples offered back-to-back at cnt=10 -> first accepted, din_ready low until the terminal cycle, second accepted at cnt=0 of the next period.
REQ-031 SHALL cover: empty buffer and din=0x80 accepted exactly on the terminal cycle -> next period pwm high for 128 cycles; underrun stays 0.
REQ-032 SHALL cover: act=0x20 and no sample offered for one full period -> underrun=1 after the terminal cycle, and pwm keeps 32-high duty; a subsequent rst pulse at cnt=100 gives all outputs 0, then period_start=1 on the first cycle after release.
REQ-033 SHALL cover, with PWM_DAC_SDM_EN defined: act=0x40 -> pwm=1 on exactly every 4th cycle, 64 ones per 256 cycles.
